// File: rtl/exu_pkg.sv
// Shared types and default sizing for the EXU issue queue slice.
package exu_pkg;

    localparam int IQ_DEPTH     = 4;
    localparam int IQ_TAG_W     = 6;
    localparam int IQ_PAYLOAD_W = 128;

    // Physical tag 0 is the hardwired-zero register and is always available.
    localparam int TAG_ZERO = 0;

    typedef struct packed {
        logic                    valid;
        logic [IQ_TAG_W-1:0]     src1_tag;
        logic                    src1_rdy;
        logic [IQ_TAG_W-1:0]     src2_tag;
        logic                    src2_rdy;
        logic [IQ_PAYLOAD_W-1:0] payload;
    } iq_entry_t;

endpackage

// File: rtl/iq_oldest_select.sv
// Lowest-index priority encoder: grants the oldest ready entry of the queue.
module iq_oldest_select #(
    parameter int N = 4
) (
    input  logic [N-1:0] ready,
    output logic [N-1:0] grant,
    output logic         found
);

    // Isolating the lowest set bit gives a one-hot grant without a loop.
    assign grant = ready & (~ready + N'(1));
    assign found = |ready;

endmodule

// File: rtl/exu_issue_queue.sv
// Collapsing, age-ordered issue queue with tag wakeup and a registered
// valid/ready issue stage feeding the single execute unit.
module exu_issue_queue
    import exu_pkg::*;
#(
    parameter int DEPTH     = IQ_DEPTH,
    parameter int TAG_W     = IQ_TAG_W,
    parameter int PAYLOAD_W = IQ_PAYLOAD_W
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       flush,
    input  logic                       disp_valid,
    output logic                       disp_ready,
    input  logic [TAG_W-1:0]           disp_src1_tag,
    input  logic [TAG_W-1:0]           disp_src2_tag,
    input  logic                       disp_src1_rdy,
    input  logic                       disp_src2_rdy,
    input  logic [PAYLOAD_W-1:0]       disp_payload,
    input  logic                       wb_valid,
    input  logic [TAG_W-1:0]           wb_tag,
    output logic                       iss_valid,
    input  logic                       iss_ready,
    output logic [PAYLOAD_W-1:0]       iss_payload,
    output logic [$clog2(DEPTH):0]     occupancy
);

    localparam int CW = $clog2(DEPTH) + 1;

    typedef struct packed {
        logic                 valid;
        logic [TAG_W-1:0]     src1_tag;
        logic                 src1_rdy;
        logic [TAG_W-1:0]     src2_tag;
        logic                 src2_rdy;
        logic [PAYLOAD_W-1:0] payload;
    } entry_t;

    entry_t               entries     [DEPTH];
    entry_t               entries_nxt [DEPTH];
    entry_t               new_entry;
    entry_t               shifted;
    logic [CW-1:0]        occ_q;
    logic [CW-1:0]        occ_nxt;
    logic [CW-1:0]        wr_idx;
    logic [DEPTH-1:0]     rdy_vec;
    logic [DEPTH-1:0]     grant;
    logic [DEPTH-1:0]     shift_mask;
    logic [PAYLOAD_W-1:0] sel_payload;
    logic                 found;
    logic                 stage_free;
    logic                 leave;
    logic                 accept;

    function automatic entry_t wake(entry_t e, logic v, logic [TAG_W-1:0] t);
        entry_t r;
        r = e;
        if (v && r.valid && r.src1_tag == t) r.src1_rdy = 1'b1;
        if (v && r.valid && r.src2_tag == t) r.src2_rdy = 1'b1;
        return r;
    endfunction

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            rdy_vec[i] = entries[i].valid & entries[i].src1_rdy & entries[i].src2_rdy;
        end
    end

    iq_oldest_select #(.N(DEPTH)) u_select (
        .ready (rdy_vec),
        .grant (grant),
        .found (found)
    );

    assign stage_free = !iss_valid || iss_ready;
    assign leave      = stage_free && found;
    assign disp_ready = occ_q < CW'(DEPTH);
    assign accept     = disp_valid && disp_ready;
    assign occupancy  = occ_q;

    // Every entry at or above the granted slot moves down by one when it leaves.
    always_comb begin
        logic seen;
        seen        = 1'b0;
        sel_payload = '0;
        for (int i = 0; i < DEPTH; i++) begin
            seen          = seen | grant[i];
            shift_mask[i] = seen;
            if (grant[i]) sel_payload = sel_payload | entries[i].payload;
        end
    end

    always_comb begin
        new_entry          = '0;
        new_entry.valid    = 1'b1;
        new_entry.src1_tag = disp_src1_tag;
        new_entry.src2_tag = disp_src2_tag;
        new_entry.payload  = disp_payload;
        new_entry.src1_rdy = disp_src1_rdy || (disp_src1_tag == TAG_W'(TAG_ZERO)) ||
                             (wb_valid && wb_tag == disp_src1_tag);
        new_entry.src2_rdy = disp_src2_rdy || (disp_src2_tag == TAG_W'(TAG_ZERO)) ||
                             (wb_valid && wb_tag == disp_src2_tag);
    end

    // Wakeup is applied after the shift so a moving entry still sees this cycle's broadcast.
    always_comb begin
        wr_idx  = leave ? (occ_q - CW'(1)) : occ_q;
        occ_nxt = occ_q + CW'(accept) - CW'(leave);
        shifted = '0;
        for (int i = 0; i < DEPTH; i++) begin
            shifted = entries[i];
            if (leave && shift_mask[i]) begin
                shifted = (i == DEPTH - 1) ? '0 : entries[(i == DEPTH - 1) ? i : i + 1];
            end
            entries_nxt[i] = wake(shifted, wb_valid, wb_tag);
            if (accept && CW'(i) == wr_idx) entries_nxt[i] = new_entry;
        end
    end

    // Flush drops queued and staged ops but keeps the last payload; reset also zeroes it.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) entries[i] <= '0;
            occ_q       <= '0;
            iss_valid   <= 1'b0;
            iss_payload <= '0;
        end else if (flush) begin
            for (int i = 0; i < DEPTH; i++) entries[i].valid <= 1'b0;
            occ_q     <= '0;
            iss_valid <= 1'b0;
        end else begin
            for (int i = 0; i < DEPTH; i++) entries[i] <= entries_nxt[i];
            occ_q <= occ_nxt;
            if (stage_free) begin
                iss_valid <= found;
                if (found) iss_payload <= sel_payload;
            end
        end
    end

endmodule

// File: doc/exu_issue_queue.md
# exu_issue_queue

Age-ordered issue queue and scheduler in front of the single execute unit. It buffers up to DEPTH dispatched micro-ops and tracks source-operand readiness from writeback tag broadcasts. Each cycle it selects the oldest ready entry and presents it to the EXU through a registered valid/ready handshake. It sits between rename/dispatch and the EXU input stage, and it is cleared by the same flush that squashes in-flight EXU instructions.

## Interface
- DEPTH, 4, number of queue entries (power of two, ≥2)
- TAG_W, 6, physical register tag width; tag 0 is the hardwired-zero register
- PAYLOAD_W, 128, opaque micro-op payload (alu_opcode, flags, funct3, rd, pcs, immediates), passed through unmodified
- clock  in  1  system clock
- reset  in  1  synchronous, active-high reset
- flush  in  1  squash all queued and staged ops (asserted together with the EXU instruction-clear)
- disp_valid  in  1  dispatch request
- disp_ready  out  1  queue can accept this cycle
- disp_src1_tag, disp_src2_tag  in  TAG_W  source tags
- disp_src1_rdy, disp_src2_rdy  in  1  source already available at dispatch
- disp_payload  in  PAYLOAD_W  micro-op body
- wb_valid  in  1  writeback broadcast valid
- wb_tag  in  TAG_W  tag being written back
- iss_valid  out  1  staged op is valid for the EXU
- iss_ready  in  1  EXU accepts (its ready_last)
- iss_payload  out  PAYLOAD_W  staged micro-op
- occupancy  out  $clog2(DEPTH)+1  number of valid entries

## Operation
- Entry fields: valid, src1_tag, src1_rdy, src2_tag, src2_rdy, payload.
- The queue is collapsing. Index 0 is always the oldest entry, and valid entries are contiguous from index 0.
- Dispatch: accepted when disp_valid & disp_ready. The new entry is written at index occupancy, or at occupancy-1 if an entry leaves the same cycle.
  - A source is marked ready if disp_srcN_rdy is set, its tag is 0, or wb_valid & wb_tag==tag in the same cycle (same-cycle bypass).
- Wakeup: every cycle with wb_valid, each valid entry whose srcN_tag==wb_tag sets srcN_rdy. Wakeup applies to entries that shift in the same cycle.
- Select: the candidate is the lowest index with valid & src1_rdy & src2_rdy. Selection uses registered ready bits only.
- Stage advance: stage_free = !iss_valid | iss_ready. When stage_free and a candidate exists:
  - the candidate moves into the issue stage;
  - entries above it shift down by one.
- When stage_free and no candidate exists, iss_valid clears on the edge.
- disp_ready = occupancy < DEPTH. It is a registered-state function and does not account for a same-cycle departure.
- Flush has priority over everything else. On the edge it clears all entry valids, iss_valid and occupancy, and ignores that cycle's dispatch and wakeup. iss_payload holds its last value.
- Tags are compared for equality only. No ordering or wrap semantics apply.

## Timing
- Reset values: iss_valid=0, iss_payload=0, occupancy=0, disp_ready=1, all entries invalid.
- Dispatch with ready sources at edge N gives iss_valid=1 after edge N+1, i.e. a 2-cycle minimum dispatch-to-issue latency.
- A wakeup at edge N makes the entry selectable in cycle N, so iss_valid=1 after edge N+1.
- iss_valid/iss_payload are stable while iss_valid & !iss_ready.
- Full with simultaneous issue: disp_ready stays 0 that cycle. Dispatch resumes the next cycle.
- Reset asserted mid-operation behaves identically to flush and additionally zeroes iss_payload.
- Throughput is one issue per cycle when iss_ready is held high and candidates exist.

## Structure
- Shared package exu_pkg:
  - iq_entry_t struct;
  - DEPTH/TAG_W/PAYLOAD_W defaults;
  - constant TAG_ZERO=0.
- One sub-module, iq_oldest_select: a combinational lowest-index priority encoder over the DEPTH ready bits, producing a one-hot grant plus found flag.
- The main module holds the entry array, the shift/append logic, the wakeup comparators and the issue stage register.

## Test plan
- Reset, then dispatch A (both srcs ready) → iss_valid=1 two edges later with payload A. occupancy goes 1 → 0 on the issue edge.
- Dispatch A(src1=5, not ready) then B (ready) → B issues first. Then wb_tag=5 → A issues one cycle after the wakeup edge.
- Fill 4 entries with iss_ready=0 → disp_ready=0 and occupancy=4. Raise iss_ready → one op per cycle, oldest-first. disp_ready=1 the cycle after the first departure.
- Dispatch with src2_tag=7 in the same cycle as wb_valid, wb_tag=7 → the entry records src2_rdy=1 and issues at the 2-cycle minimum.
- Three entries queued, iss_valid=1 stalled, flush together with disp_valid=1 → next cycle occupancy=0, iss_valid=0, and the dispatched op is discarded.
- Dispatch with src tags 0/0 and rdy bits 0 → treated as ready and issues at minimum latency.
